// File: rtl/rv_pkg.sv
// Shared encodings and the decoded-record layout for the RV32I decode stage.
// Pure definitions, no logic, no latency.
// Not applicable: no flow control lives here.
package rv_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // funct7 values that select the base / alternate (SUB, SRA) operation
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SLL  = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b010;
   localparam logic [2:0] ALU_SLTU = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b100;
   localparam logic [2:0] ALU_SRL  = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b111;

   // Operand selects
   localparam logic [1:0] SRC1_RS1  = 2'b00;
   localparam logic [1:0] SRC1_PC   = 2'b01;
   localparam logic [1:0] SRC1_ZERO = 2'b10;
   localparam logic [1:0] SRC2_RS2  = 2'b00;
   localparam logic [1:0] SRC2_IMM  = 2'b01;
   localparam logic [1:0] SRC2_FOUR = 2'b10;

   // Instruction classes
   localparam logic [2:0] CLS_ALU     = 3'b000;
   localparam logic [2:0] CLS_LOAD    = 3'b001;
   localparam logic [2:0] CLS_STORE   = 3'b010;
   localparam logic [2:0] CLS_BRANCH  = 3'b011;
   localparam logic [2:0] CLS_JAL     = 3'b100;
   localparam logic [2:0] CLS_JALR    = 3'b101;
   localparam logic [2:0] CLS_ILLEGAL = 3'b111;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  alu_op;
      logic        alu_mod;
      logic [1:0]  src1_sel;
      logic [1:0]  src2_sel;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        rd_we;
      logic [2:0]  cls;
      logic [2:0]  funct3;
   } dec_rec_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Combinational RV32I decoder: instruction word + pc -> one decoded record.
// Zero latency (pure logic).
// No flow control; the enclosing stage handles valid/ready.
import rv_pkg::*;

module rv_decode_comb (
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output dec_rec_t    rec
);

   logic [6:0]  opc;
   logic [4:0]  f_rd;
   logic [2:0]  f3;
   logic [4:0]  f_rs1;
   logic [4:0]  f_rs2;
   logic [6:0]  f7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign opc   = instr[6:0];
   assign f_rd  = instr[11:7];
   assign f3    = instr[14:12];
   assign f_rs1 = instr[19:15];
   assign f_rs2 = instr[24:20];
   assign f7    = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   logic        legal;
   logic [2:0]  alu_op;
   logic        alu_mod;
   logic [1:0]  src1_sel;
   logic [1:0]  src2_sel;
   logic        use_rs1;
   logic        use_rs2;
   logic        use_rd;
   logic [31:0] imm;
   logic [2:0]  cls;

   // Classify the opcode: legality, ALU control, operand selects and which fields are live
   always_comb begin
      legal    = 1'b0;
      alu_op   = ALU_ADD;
      alu_mod  = 1'b0;
      src1_sel = SRC1_RS1;
      src2_sel = SRC2_RS2;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      use_rd   = 1'b0;
      imm      = 32'h0;
      cls      = CLS_ALU;
      case (opc)
         OPC_OP: begin
            legal   = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == ALU_ADD) || (f3 == ALU_SRL)));
            alu_op  = f3;
            alu_mod = instr[30];
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
         end
         OPC_OP_IMM: begin
            // funct7 is only meaningful for the shift-immediates; elsewhere it is immediate bits
            case (f3)
               ALU_SLL: legal = (f7 == F7_BASE);
               ALU_SRL: legal = (f7 == F7_BASE) || (f7 == F7_ALT);
               default: legal = 1'b1;
            endcase
            alu_op   = f3;
            alu_mod  = (f3 == ALU_SRL) && instr[30];
            src2_sel = SRC2_IMM;
            imm      = imm_i;
            use_rs1  = 1'b1;
            use_rd   = 1'b1;
         end
         OPC_LUI: begin
            legal    = 1'b1;
            src1_sel = SRC1_ZERO;
            src2_sel = SRC2_IMM;
            imm      = imm_u;
            use_rd   = 1'b1;
         end
         OPC_AUIPC: begin
            legal    = 1'b1;
            src1_sel = SRC1_PC;
            src2_sel = SRC2_IMM;
            imm      = imm_u;
            use_rd   = 1'b1;
         end
         OPC_LOAD: begin
            legal    = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            src2_sel = SRC2_IMM;
            imm      = imm_i;
            use_rs1  = 1'b1;
            use_rd   = 1'b1;
            cls      = CLS_LOAD;
         end
         OPC_STORE: begin
            legal    = (f3[2] == 1'b0) && (f3 != 3'b011);
            src2_sel = SRC2_IMM;
            imm      = imm_s;
            use_rs1  = 1'b1;
            use_rs2  = 1'b1;
            cls      = CLS_STORE;
         end
         OPC_BRANCH: begin
            // BEQ/BNE compare by subtraction, signed/unsigned orderings by set-less-than
            legal   = (f3[2:1] != 2'b01);
            alu_op  = !f3[2] ? ALU_ADD : (f3[1] ? ALU_SLTU : ALU_SLT);
            alu_mod = !f3[2];
            imm     = imm_b;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            cls     = CLS_BRANCH;
         end
         OPC_JAL: begin
            legal    = 1'b1;
            src1_sel = SRC1_PC;
            src2_sel = SRC2_FOUR;
            imm      = imm_j;
            use_rd   = 1'b1;
            cls      = CLS_JAL;
         end
         OPC_JALR: begin
            legal    = (f3 == 3'b000);
            src1_sel = SRC1_PC;
            src2_sel = SRC2_FOUR;
            imm      = imm_i;
            use_rs1  = 1'b1;
            use_rd   = 1'b1;
            cls      = CLS_JALR;
         end
         default: legal = 1'b0;
      endcase
   end

   // Assemble the record; illegal encodings collapse to a bare marker that still carries pc/funct3
   always_comb begin
      rec        = '0;
      rec.pc     = pc;
      rec.funct3 = f3;
      if (legal) begin
         rec.alu_op   = alu_op;
         rec.alu_mod  = alu_mod;
         rec.src1_sel = src1_sel;
         rec.src2_sel = src2_sel;
         rec.rs1      = use_rs1 ? f_rs1 : 5'd0;
         rec.rs2      = use_rs2 ? f_rs2 : 5'd0;
         rec.rd       = use_rd  ? f_rd  : 5'd0;
         rec.imm      = imm;
         rec.rd_we    = use_rd && (f_rd != 5'd0);
         rec.cls      = cls;
      end else begin
         rec.cls      = CLS_ILLEGAL;
      end
   end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage between fetch and execute (output reg + one skid entry).
// Latency: accept at edge N -> out_valid at edge N+1; one instruction per cycle sustained.
// Backpressure: stalled output parks the next accept in the skid; in_ready (a flop) drops once the skid is full.
import rv_pkg::*;

module rv_decode_stage #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [2:0]      out_alu_op,
   output logic            out_alu_mod,
   output logic [1:0]      out_src1_sel,
   output logic [1:0]      out_src2_sel,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_rd_we,
   output logic [2:0]      out_cls,
   output logic [2:0]      out_funct3
);

   dec_rec_t dec_rec;
   dec_rec_t out_rec_q;
   dec_rec_t skid_rec_q;
   logic     out_vld_q;
   logic     skid_vld_q;
   logic     in_rdy_q;

   logic     out_vld_n;
   logic     skid_vld_n;
   logic     ld_out_skid;
   logic     ld_out_in;
   logic     ld_skid;
   logic     accept;
   logic     out_free;

   rv_decode_comb u_dec (
      .instr (in_instr),
      .pc    (in_pc),
      .rec   (dec_rec)
   );

   assign accept   = in_valid && in_rdy_q;
   assign out_free = !out_vld_q || out_ready;

   // Occupancy update: the output register drains from the skid first, so order is preserved
   always_comb begin
      out_vld_n   = out_vld_q;
      skid_vld_n  = skid_vld_q;
      ld_out_skid = 1'b0;
      ld_out_in   = 1'b0;
      ld_skid     = 1'b0;
      if (flush) begin
         out_vld_n  = 1'b0;
         skid_vld_n = 1'b0;
      end else if (out_free) begin
         // in_ready is low whenever the skid holds a record, so no accept competes with the drain
         if (skid_vld_q) begin
            ld_out_skid = 1'b1;
            out_vld_n   = 1'b1;
            skid_vld_n  = 1'b0;
         end else begin
            ld_out_in = accept;
            out_vld_n = accept;
         end
      end else if (accept) begin
         ld_skid    = 1'b1;
         skid_vld_n = 1'b1;
      end
   end

   // Valid bits and the registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         in_rdy_q   <= 1'b1;
      end else begin
         out_vld_q  <= out_vld_n;
         skid_vld_q <= skid_vld_n;
         in_rdy_q   <= !skid_vld_n;
      end
   end

   // Record payloads; the output register keeps its contents while stalled or empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_rec_q    <= '0;
         out_rec_q.pc <= RESET_PC;
         skid_rec_q   <= '0;
      end else begin
         if (ld_out_skid) begin
            out_rec_q <= skid_rec_q;
         end else if (ld_out_in) begin
            out_rec_q <= dec_rec;
         end
         if (ld_skid) begin
            skid_rec_q <= dec_rec;
         end
      end
   end

   assign in_ready     = in_rdy_q;
   assign out_valid    = out_vld_q;
   assign out_pc       = out_rec_q.pc;
   assign out_alu_op   = out_rec_q.alu_op;
   assign out_alu_mod  = out_rec_q.alu_mod;
   assign out_src1_sel = out_rec_q.src1_sel;
   assign out_src2_sel = out_rec_q.src2_sel;
   assign out_rs1      = out_rec_q.rs1;
   assign out_rs2      = out_rec_q.rs2;
   assign out_rd       = out_rec_q.rd;
   assign out_imm      = out_rec_q.imm;
   assign out_rd_we    = out_rec_q.rd_we;
   assign out_cls      = out_rec_q.cls;
   assign out_funct3   = out_rec_q.funct3;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed decode cases, skid/flush/reset scenarios, random traffic.
// Expected records come from a reference decoder inside the bench and flow through a scoreboard queue.
// A negedge monitor pops and compares on every output handshake and checks stability under stall.
module tb_rv_decode_stage;

   localparam logic [31:0] RST_PC = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  op;
      logic        mod;
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        we;
      logic [2:0]  cls;
      logic [2:0]  f3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [2:0]  out_alu_op;
   logic        out_alu_mod;
   logic [1:0]  out_src1_sel;
   logic [1:0]  out_src2_sel;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic        out_rd_we;
   logic [2:0]  out_cls;
   logic [2:0]  out_funct3;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   rv_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_alu_op   (out_alu_op),
      .out_alu_mod  (out_alu_mod),
      .out_src1_sel (out_src1_sel),
      .out_src2_sel (out_src2_sel),
      .out_rs1      (out_rs1),
      .out_rs2      (out_rs2),
      .out_rd       (out_rd),
      .out_imm      (out_imm),
      .out_rd_we    (out_rd_we),
      .out_cls      (out_cls),
      .out_funct3   (out_funct3)
   );

   always #5 clk = ~clk;

   function automatic exp_t dut_rec();
      return {out_pc, out_alu_op, out_alu_mod, out_src1_sel, out_src2_sel,
              out_rs1, out_rs2, out_rd, out_imm, out_rd_we, out_cls, out_funct3};
   endfunction

   function automatic exp_t fill(input exp_t b, input logic [2:0] op, input logic mod,
                                 input logic [1:0] s1, input logic [1:0] s2,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic we, input logic [2:0] cls);
      exp_t e = b;
      e.op = op; e.mod = mod; e.s1 = s1; e.s2 = s2;
      e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = imm;
      e.we = we && (rd != 5'd0);
      e.cls = cls;
      return e;
   endfunction

   // Reference decoder, written straight from the instruction-set rules
   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      exp_t        e;
      logic [31:0] sg, ii, is_, ib, iu, ij;
      logic [2:0]  f3  = i[14:12];
      logic [6:0]  f7  = i[31:25];
      logic [4:0]  rs1 = i[19:15];
      logic [4:0]  rs2 = i[24:20];
      logic [4:0]  rd  = i[11:7];
      sg  = i[31] ? 32'hFFFF_FFFF : 32'h0;
      ii  = (sg << 12) + 32'(i[31:20]);
      is_ = (sg << 12) + 32'({i[31:25], i[11:7]});
      ib  = (sg << 13) + 32'({i[31], i[7], i[30:25], i[11:8]}) * 2;
      iu  = i & 32'hFFFF_F000;
      ij  = (sg << 21) + 32'({i[31], i[19:12], i[20], i[30:21]}) * 2;
      e     = '0;
      e.pc  = pc;
      e.f3  = f3;
      e.cls = 3'd7;
      case (i[6:0])
         7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))
                   e = fill(e, f3, i[30], 0, 0, rs1, rs2, rd, 0, 1, 0);
         7'h13: if ((f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1)
                   e = fill(e, f3, (f3 == 5) && i[30], 0, 1, rs1, 0, rd, ii, 1, 0);
         7'h37: e = fill(e, 0, 0, 2, 1, 0, 0, rd, iu, 1, 0);
         7'h17: e = fill(e, 0, 0, 1, 1, 0, 0, rd, iu, 1, 0);
         7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)
                   e = fill(e, 0, 0, 0, 1, rs1, 0, rd, ii, 1, 1);
         7'h23: if (f3 <= 2)
                   e = fill(e, 0, 0, 0, 1, rs1, rs2, 0, is_, 0, 2);
         7'h63: begin
            if (f3 == 0 || f3 == 1)      e = fill(e, 0, 1, 0, 0, rs1, rs2, 0, ib, 0, 3);
            else if (f3 == 4 || f3 == 5) e = fill(e, 2, 0, 0, 0, rs1, rs2, 0, ib, 0, 3);
            else if (f3 == 6 || f3 == 7) e = fill(e, 3, 0, 0, 0, rs1, rs2, 0, ib, 0, 3);
         end
         7'h6F: e = fill(e, 0, 0, 1, 2, 0, 0, rd, ij, 1, 4);
         7'h67: if (f3 == 0)
                   e = fill(e, 0, 0, 1, 2, rs1, 0, rd, ii, 1, 5);
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      int          k = $urandom_range(0, 10);
      case (k)
         0: r[6:0] = 7'h33;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h37;
         3: r[6:0] = 7'h17;  4: r[6:0] = 7'h03;  5: r[6:0] = 7'h23;
         6: r[6:0] = 7'h63;  7: r[6:0] = 7'h6F;  8: r[6:0] = 7'h67;
         9: r[6:0] = 7'h13;  default: ;
      endcase
      k = $urandom_range(0, 3);
      if (k == 0) r[31:25] = 7'h00;
      else if (k == 1) r[31:25] = 7'h20;
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   task automatic check_idle(input string name);
      exp_t z = '0;
      z.pc = RST_PC;
      check({name, "_valid"}, 128'(out_valid), 128'(1'b0));
      check({name, "_ready"}, 128'(in_ready), 128'(1'b1));
      check({name, "_rec"}, 128'(dut_rec()), 128'(z));
   endtask

   // One clock of stimulus; the scoreboard learns of accepted (and not flushed) instructions
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, output logic acc);
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      acc = v && in_ready;
      if (fl) sb.delete();
      else if (acc) sb.push_back(ref_decode(ins, pc));
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every output handshake against the scoreboard, and hold-stability under stall
   exp_t prev_rec;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t act;
      exp_t want;
      act = dut_rec();
      if (rst_n && out_valid && prev_stall) begin
         n_checks++;
         if (act !== prev_rec) begin
            n_fail++;
            $display("FAIL hold_stable: got %h, expected %h", act, prev_rec);
         end
      end
      if (rst_n && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got record %h, expected no output", act);
         end else begin
            want = sb.pop_front();
            if (act !== want) begin
               n_fail++;
               $display("FAIL record pc=%h: got %h, expected %h", want.pc, act, want);
            end
         end
      end
      prev_stall <= rst_n && out_valid && !out_ready;
      prev_rec   <= act;
   end

   initial begin
      logic        a;
      logic [31:0] cur;
      logic        have;
      logic [31:0] rpc;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      rst_n = 1'b1;

      // Directed decodes, each checked one cycle after acceptance
      step(1, 32'h002081B3, 32'h100, 1, 0, a);
      check("add_valid", 128'(out_valid), 128'(1'b1));
      check("add_fields", 128'({out_alu_op, out_alu_mod, out_rs1, out_rs2, out_rd, out_rd_we, out_cls}),
            128'({3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 3'b000}));
      step(1, 32'h40435293, 32'h104, 1, 0, a);
      check("srai", 128'({out_alu_op, out_alu_mod, out_src2_sel, out_imm}),
            128'({3'b101, 1'b1, 2'b01, 32'h404}));
      step(1, 32'h00435293, 32'h108, 1, 0, a);
      check("srli", 128'({out_alu_op, out_alu_mod}), 128'({3'b101, 1'b0}));
      step(1, 32'hFFF08093, 32'h10C, 1, 0, a);
      check("addi_neg", 128'({out_alu_op, out_alu_mod, out_imm}), 128'({3'b000, 1'b0, 32'hFFFF_FFFF}));
      step(1, 32'h0000207F, 32'h110, 1, 0, a);
      check("bad_opcode", 128'({out_cls, out_rd_we, out_alu_op, out_alu_mod, out_imm}),
            128'({3'b111, 1'b0, 3'b000, 1'b0, 32'h0}));
      step(1, 32'h0000A063, 32'h114, 1, 0, a);
      check("bad_branch", 128'({out_cls, out_rd_we}), 128'({3'b111, 1'b0}));
      step(0, 32'h0, 32'h0, 1, 0, a);

      // Skid: stall the output right after the first of four back-to-back instructions
      step(1, 32'h00100093, 32'h200, 0, 0, a);
      step(1, 32'h00200113, 32'h204, 0, 0, a);
      check("skid_ready_low", 128'(in_ready), 128'(1'b0));
      check("skid_head_pc", 128'(out_pc), 128'(32'h200));
      step(1, 32'h00300193, 32'h208, 0, 0, a);
      check("skid_blocks_accept", 128'(a), 128'(1'b0));
      have = 1'b1; cur = 32'h00300193; rpc = 32'h208;
      for (int c = 0; c < 12 && have; c++) begin
         step(1, cur, rpc, 1, 0, a);
         if (a) begin
            if (rpc == 32'h20C) have = 1'b0;
            else begin cur = 32'h00400213; rpc = 32'h20C; end
         end
      end
      check("skid_all_offered", 128'(have), 128'(1'b0));
      repeat (4) step(0, 32'h0, 32'h0, 1, 0, a);

      // Flush with two records held and fetch still offering
      step(1, 32'h00500293, 32'h300, 0, 0, a);
      step(1, 32'h00600313, 32'h304, 0, 0, a);
      step(1, 32'h00700393, 32'h308, 0, 1, a);
      check("flush_full_valid", 128'(out_valid), 128'(1'b0));
      check("flush_full_ready", 128'(in_ready), 128'(1'b1));
      // Flush overriding a same-cycle accept
      step(1, 32'h00800413, 32'h30C, 0, 0, a);
      step(1, 32'h00900493, 32'h310, 0, 1, a);
      check("flush_accept_hs", 128'(a), 128'(1'b1));
      check("flush_accept_valid", 128'(out_valid), 128'(1'b0));
      repeat (3) step(0, 32'h0, 32'h0, 1, 0, a);

      // Asynchronous reset in the middle of a stall
      step(1, 32'h00A00513, 32'h400, 0, 0, a);
      step(1, 32'h00B00593, 32'h404, 0, 0, a);
      #2;
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check_idle("reset_mid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 32'h0, 32'h0, 1, 0, a);
      check("post_reset_ready", 128'(in_ready), 128'(1'b1));

      // Random traffic with random backpressure and occasional flushes
      have = 1'b0; rpc = 32'h1000; cur = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         logic v, ordy, fl;
         if (!have) begin cur = rand_instr(); have = 1'b1; end
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 49) == 0);
         if (fl) ordy = 1'b0;
         step(v, cur, rpc, ordy, fl, a);
         if (a) begin have = 1'b0; rpc = rpc + 32'd4; end
      end
      for (int c = 0; c < 10; c++) step(0, 32'h0, 32'h0, 1, 0, a);
      check("drain_empty", 128'(sb.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
